and_path_monitor: RTL and testbench

Runtime integrity checker that sits beside the registered two-input AND datapath (y = a & b, two register stages) on the iCE40 fabric. Keeps a shadow pipeline of the expected output, compares it cycle-by-cycle against the observed `y`, and flags divergence. Divergence is what an unauthorised routing-injected select on the output mux would cause. It is the checking end of that datapath: the datapath produces `y`, this block consumes and validates it.

---
 rtl/and_path_monitor_if.sv | 26 ++
 rtl/and_path_monitor.sv | 133 +++++++++++++
 tb/tb_and_path_monitor.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/and_path_monitor_if.sv
// Bundles the monitored AND datapath signals (a, b, observed y, clear)
// together with the monitor status outputs.
interface and_path_monitor_if #(
  parameter int CNT_W = 8
) ();
  logic             a;
  logic             b;
  logic             y;
  logic             clr;
  logic             armed;
  logic             mismatch;
  logic             alarm;
  logic [CNT_W-1:0] err_count;

  // Datapath / supervisor side: drives the observed signals, reads status.
  modport master (
    output a, b, y, clr,
    input  armed, mismatch, alarm, err_count
  );

  // Monitor side: observes the datapath, reports status.
  modport slave (
    input  a, b, y, clr,
    output armed, mismatch, alarm, err_count
  );
endinterface

// File: rtl/and_path_monitor.sv
// Runtime integrity checker for a registered two-input AND datapath.
// Keeps a shadow pipeline of a & b that is LATENCY stages deep, compares
// its tail against the observed y every cycle once the pipeline is full,
// counts divergences and raises a sticky alarm after THRESH in a row.
module and_path_monitor #(
  parameter int LATENCY = 2,
  parameter int CNT_W   = 8,
  parameter int THRESH  = 3
) (
  input logic            clk,
  input logic            rst,
  and_path_monitor_if.slave mon
);

  localparam int               WARM_W    = $clog2(LATENCY + 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(LATENCY - 1);
  localparam logic [7:0]        THRESH_C  = 8'(THRESH);
  localparam logic [CNT_W-1:0]  ERR_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_WARMUP = 2'b00,
    ST_ARMED  = 2'b01,
    ST_ALARM  = 2'b10
  } state_t;

  state_t             state_q,     state_d;
  logic [LATENCY-1:0] shadow_q,    shadow_d;
  logic [WARM_W-1:0]  warm_cnt_q,  warm_cnt_d;
  logic [7:0]         run_cnt_q,   run_cnt_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic               armed_q,     armed_d;
  logic               mismatch_q,  mismatch_d;
  logic               alarm_q,     alarm_d;

  logic               tail_s;
  logic               miss_s;

  // Next-state logic: shadow shift, warmup count, compare and counters.
  always_comb begin
    shadow_d    = shadow_q;
    state_d     = state_q;
    warm_cnt_d  = warm_cnt_q;
    run_cnt_d   = run_cnt_q;
    err_count_d = err_count_q;
    mismatch_d  = 1'b0;

    // The shadow pipeline always shifts, independent of state or clr.
    shadow_d[0] = mon.a & mon.b;
    for (int i = 1; i < LATENCY; i++) begin
      shadow_d[i] = shadow_q[i-1];
    end

    tail_s = shadow_q[LATENCY-1];
    miss_s = (state_q != ST_WARMUP) && (mon.y != tail_s);

    case (state_q)
      ST_WARMUP: begin
        // clr does not disturb a warmup in progress; counters are already 0.
        if (warm_cnt_q == WARM_LAST) begin
          state_d = ST_ARMED;
        end else begin
          warm_cnt_d = warm_cnt_q + 1'b1;
        end
      end
      ST_ARMED, ST_ALARM: begin
        if (mon.clr) begin
          // Clear wins over a coincident miss; that miss is dropped.
          state_d     = ST_ARMED;
          run_cnt_d   = 8'd0;
          err_count_d = {CNT_W{1'b0}};
          mismatch_d  = 1'b0;
        end else begin
          mismatch_d = miss_s;
          if (miss_s) begin
            if (err_count_q == ERR_MAX) begin
              err_count_d = err_count_q;
            end else begin
              err_count_d = err_count_q + 1'b1;
            end
            if (run_cnt_q >= THRESH_C) begin
              run_cnt_d = THRESH_C;
            end else begin
              run_cnt_d = run_cnt_q + 8'd1;
            end
          end else begin
            run_cnt_d = 8'd0;
          end
          // ALARM is sticky; only ARMED can step up into it.
          if ((state_q == ST_ARMED) && (run_cnt_d == THRESH_C)) begin
            state_d = ST_ALARM;
          end else begin
            state_d = state_q;
          end
        end
      end
      default: begin
        state_d = ST_WARMUP;
      end
    endcase

    armed_d = (state_d != ST_WARMUP);
    alarm_d = (state_d == ST_ALARM);
  end

  // State, shadow pipeline and registered outputs; rst forces all to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_WARMUP;
      shadow_q    <= {LATENCY{1'b0}};
      warm_cnt_q  <= {WARM_W{1'b0}};
      run_cnt_q   <= 8'd0;
      err_count_q <= {CNT_W{1'b0}};
      armed_q     <= 1'b0;
      mismatch_q  <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      warm_cnt_q  <= warm_cnt_d;
      run_cnt_q   <= run_cnt_d;
      err_count_q <= err_count_d;
      armed_q     <= armed_d;
      mismatch_q  <= mismatch_d;
      alarm_q     <= alarm_d;
    end
  end

  assign mon.armed     = armed_q;
  assign mon.mismatch  = mismatch_q;
  assign mon.alarm     = alarm_q;
  assign mon.err_count = err_count_q;

endmodule

// File: tb/tb_and_path_monitor.sv
// Directed bench for and_path_monitor: a vector table for the basic
// compare/count/alarm/clear behaviour plus hand-written multi-cycle cases.
module tb_and_path_monitor;

  logic clk;
  logic rst;

  and_path_monitor_if #(.CNT_W(8)) bus ();

  and_path_monitor #(
    .LATENCY (2),
    .CNT_W   (8),
    .THRESH  (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mon (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       a;
    logic       b;
    logic       flip;
    logic       clr;
    logic       e_armed;
    logic       e_mis;
    logic       e_alarm;
    logic [7:0] e_err;
  } vec_t;

  vec_t tbl [17];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference datapath: two register stages of a & b.
  logic dp1 = 1'b0;
  logic dp2 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_armed, input logic e_mis,
                           input logic e_alarm, input logic [7:0] e_err);
    check({tag, ".armed"},    {31'd0, bus.armed},    {31'd0, e_armed});
    check({tag, ".mismatch"}, {31'd0, bus.mismatch}, {31'd0, e_mis});
    check({tag, ".alarm"},    {31'd0, bus.alarm},    {31'd0, e_alarm});
    check({tag, ".err"},      {24'd0, bus.err_count}, {24'd0, e_err});
  endtask

  // One clock: present inputs (y is the reference output, optionally
  // inverted), take the edge, then advance the reference datapath.
  task automatic step(input logic ia, input logic ib, input logic iflip, input logic iclr);
    bus.a   = ia;
    bus.b   = ib;
    bus.clr = iclr;
    bus.y   = dp2 ^ iflip;
    @(posedge clk);
    #1;
    dp2 = dp1;
    dp1 = ia & ib;
  endtask

  initial begin
    //         a     b     flip  clr   armed mis   alarm err
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd3};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd4};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd5};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd6};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd6};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd6};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};

    bus.a = 1'b0; bus.b = 1'b0; bus.y = 1'b0; bus.clr = 1'b0;
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check_all("reset", 1'b0, 1'b0, 1'b0, 8'd0);
    rst = 1'b0;

    // Vector table: warmup, single/run mismatches, alarm, clr with miss.
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].a, tbl[i].b, tbl[i].flip, tbl[i].clr);
      check_all($sformatf("vec%0d", i), tbl[i].e_armed, tbl[i].e_mis,
                tbl[i].e_alarm, tbl[i].e_err);
    end

    // 50 clean cycles with a = b = 1 after a clear.
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check_all("clean_clr", 1'b1, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 50; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check_all($sformatf("clean%0d", i), 1'b1, 1'b0, 1'b0, 8'd0);
    end

    // Single wrong y where expected is 0: one pulse, count 1, no alarm.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check_all("single", 1'b1, 1'b1, 1'b0, 8'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_all("single_after", 1'b1, 1'b0, 1'b0, 8'd1);

    // Three in a row raise alarm on the third pulse; stays for 20 cycles.
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check_all("three_clr", 1'b1, 1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check_all("three_1", 1'b1, 1'b1, 1'b0, 8'd1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check_all("three_2", 1'b1, 1'b1, 1'b0, 8'd2);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check_all("three_3", 1'b1, 1'b1, 1'b1, 8'd3);
    for (int i = 0; i < 20; i++) begin
      step(i[0], 1'b1, 1'b0, 1'b0);
      check_all($sformatf("sticky%0d", i), 1'b1, 1'b0, 1'b1, 8'd3);
    end

    // 300 consecutive mismatches saturate the counter at 255.
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check_all("sat_clr", 1'b1, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 300; i++) begin
      step(i[1], i[0], 1'b1, 1'b0);
    end
    check_all("sat", 1'b1, 1'b1, 1'b1, 8'd255);

    // clr in ALARM coinciding with a miss: everything cleared, miss dropped.
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check_all("clr_miss", 1'b1, 1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check_all("clr_miss_after", 1'b1, 1'b0, 1'b0, 8'd0);

    // Reach ALARM again, then pulse rst between edges.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check_all("pre_rst", 1'b1, 1'b1, 1'b1, 8'd3);
    #1 rst = 1'b1;
    #1 check_all("async_rst", 1'b0, 1'b0, 1'b0, 8'd0);
    #1 rst = 1'b0;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check_all("rwarm1", 1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check_all("rwarm2", 1'b1, 1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check_all("rfirst", 1'b1, 1'b1, 1'b0, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
